// File: rtl/sbox_bram_scheduler.sv
// sbox_bram_scheduler: streams one 128-bit masked share through a shared
// dual-port masked S-box BRAM. Two bytes are looked up per cycle (even byte
// on port A, odd byte on port B). The results are collected, and the whole
// block is presented once it is complete.
module sbox_bram_scheduler #(
    parameter int NB     = 16,
    parameter int SEL_W  = 2,
    parameter int RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NB-1:0]       in_state,
    input  logic [SEL_W*NB-1:0]   in_sel,
    input  logic                  flush,
    output logic                  bram_en,
    output logic                  bram_rst,
    output logic [SEL_W+7:0]      bram_addra,
    output logic [SEL_W+7:0]      bram_addrb,
    input  logic [7:0]            bram_doa,
    input  logic [7:0]            bram_dob,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NB-1:0]       out_state,
    output logic                  busy
);

    localparam int NI  = NB / 2;
    localparam int K_W = (NI > 1) ? $clog2(NI) : 1;
    localparam int D_W = $clog2(RD_LAT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state;
    logic [K_W-1:0]        k;
    logic [K_W-1:0]        k_nxt;
    logic [D_W-1:0]        dcnt;
    logic                  rst_seen;
    logic                  accept;
    logic                  last_issue;
    logic [8*NB-1:0]       lat_state;
    logic [SEL_W*NB-1:0]   lat_sel;
    logic [8*NB-1:0]       res;
    logic [8*NB-1:0]       res_next;
    logic [SEL_W+7:0]      nxt_a;
    logic [SEL_W+7:0]      nxt_b;
    logic [RD_LAT-1:0]     pv;
    logic [K_W-1:0]        pidx [RD_LAT];

    assign in_ready   = rst && (state == S_IDLE) && !bram_rst && !flush;
    assign accept     = in_valid && in_ready;
    assign busy       = (state != S_IDLE);
    assign last_issue = (k == K_W'(NI - 1));
    assign k_nxt      = k + 1'b1;

    // Addresses for the byte pair of the next issue cycle, taken from the latched block
    always_comb begin
        nxt_a = {lat_sel[2*SEL_W*int'(k_nxt) +: SEL_W],         lat_state[16*int'(k_nxt) +: 8]};
        nxt_b = {lat_sel[2*SEL_W*int'(k_nxt) + SEL_W +: SEL_W], lat_state[16*int'(k_nxt) + 8 +: 8]};
    end

    // Merge the BRAM data whose lookup reaches the end of the read pipe this cycle
    always_comb begin
        // NOTE: a default on entry to every combinational block keeps partial assignments from inferring latches.
        res_next = res;
        if (bram_en && pv[RD_LAT-1]) begin
            res_next[16*int'(pidx[RD_LAT-1]) +: 8]     = bram_doa;
            res_next[16*int'(pidx[RD_LAT-1]) + 8 +: 8] = bram_dob;
        end
    end

    // BRAM reset: held through reset and one cycle past release, pulsed the cycle after a flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_seen <= 1'b0;
            bram_rst <= 1'b1;
        end else begin
            rst_seen <= 1'b1;
            bram_rst <= flush | ~rst_seen;
        end
    end

    // Control FSM: accept, issue address pairs, drain the read latency, present result
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: every register here uses non-blocking assignment so all updates see pre-edge values.
        if (!rst) begin
            state      <= S_IDLE;
            k          <= '0;
            dcnt       <= '0;
            bram_en    <= 1'b0;
            bram_addra <= '0;
            bram_addrb <= '0;
            out_valid  <= 1'b0;
            out_state  <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            k         <= '0;
            dcnt      <= '0;
            bram_en   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state      <= S_ISSUE;
                        k          <= '0;
                        bram_en    <= 1'b1;
                        bram_addra <= {in_sel[SEL_W-1:0],       in_state[7:0]};
                        bram_addrb <= {in_sel[2*SEL_W-1:SEL_W], in_state[15:8]};
                    end
                end
                S_ISSUE: begin
                    if (last_issue) begin
                        state <= S_DRAIN;
                        dcnt  <= '0;
                    end else begin
                        k          <= k_nxt;
                        bram_addra <= nxt_a;
                        bram_addrb <= nxt_b;
                    end
                end
                S_DRAIN: begin
                    if (dcnt == D_W'(RD_LAT - 1)) begin
                        state     <= S_DONE;
                        bram_en   <= 1'b0;
                        out_valid <= 1'b1;
                        out_state <= res_next;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Capture-valid pipe: advances only on enabled BRAM cycles, cleared by flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv <= '0;
        end else if (flush) begin
            pv <= '0;
        end else if (bram_en) begin
            pv[0] <= (state == S_ISSUE);
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
            end
        end
    end

    // Datapath storage: latched block, capture indices, partial result
    always_ff @(posedge clk) begin
        // NOTE: pure data registers skip reset; they are always written before their contents are used.
        if (accept) begin
            lat_state <= in_state;
            lat_sel   <= in_sel;
        end
        if (bram_en) begin
            pidx[0] <= k;
            for (int i = 1; i < RD_LAT; i++) begin
                pidx[i] <= pidx[i-1];
            end
        end
        res <= res_next;
    end

endmodule
